// File: rtl/dense_tick_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dense_seq_pkg                                                   |
// | Purpose  : Shared definitions for the dense-layer tick sequencer: FSM      |
// |            state encoding and default layer geometry.                      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package dense_seq_pkg;

  localparam int unsigned N_IN_DEF  = 16;
  localparam int unsigned N_OUT_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/dense_tick_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dense_tick_sequencer_if                                         |
// | Purpose  : Control/strobe bundle between a tick source + controller and    |
// |            the dense-layer sequencer.                                      |
// | Ports    : master drives tick_in/start/abort and observes the rest;        |
// |            slave (the sequencer) is the mirror image.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface dense_tick_sequencer_if #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 4,
  parameter int unsigned WA_W  = 8
);
  logic             tick_in;
  logic             start;
  logic             abort;
  logic             busy;
  logic [IN_W-1:0]  in_idx;
  logic [OUT_W-1:0] out_idx;
  logic [WA_W-1:0]  w_addr;
  logic             mac_clr;
  logic             mac_en;
  logic             acc_store;
  logic             done;
  logic             tick_err;

  modport master (
    output tick_in, start, abort,
    input  busy, in_idx, out_idx, w_addr, mac_clr, mac_en, acc_store, done, tick_err
  );

  modport slave (
    input  tick_in, start, abort,
    output busy, in_idx, out_idx, w_addr, mac_clr, mac_en, acc_store, done, tick_err
  );
endinterface
`default_nettype wire

// File: rtl/dense_tick_sequencer_tick_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tick_edge_detect                                                |
// | Purpose  : Rising-edge detector for a same-clock level tick. A tick held   |
// |            high for many cycles yields a single rise; a tick already high  |
// |            when reset releases is seen as a rise on the first cycle.       |
// | Ports    : clock_in  system clock                                          |
// |            rst       asynchronous active-low reset                         |
// |            tick_i    level tick input                                      |
// |            rise_o    combinational one-cycle rise indication               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tick_edge_detect (
  input  logic clock_in,
  input  logic rst,
  input  logic tick_i,
  output logic rise_o
);

  logic tick_q;

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_i;
    end
  end

  assign rise_o = tick_i & ~tick_q;

endmodule
`default_nettype wire

// File: rtl/dense_tick_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dense_tick_sequencer                                            |
// | Purpose  : Turns each rising edge of the divided tick into one dense-layer |
// |            step: clear / N_IN accumulates / store per neuron, for N_OUT    |
// |            neurons, then a single done pulse.                              |
// | Ports    : clock_in  system clock                                          |
// |            rst       asynchronous active-low reset                         |
// |            bus       dense_tick_sequencer_if.slave (tick_in, start, abort  |
// |                      in; busy, indices, w_addr, strobes, done, tick_err)   |
// | Options  : TICK_WATCHDOG_EN - abort the pass with sticky tick_err when no  |
// |            tick rise arrives for WDOG_CYCLES busy cycles.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dense_tick_sequencer
  import dense_seq_pkg::*;
#(
  parameter int unsigned N_IN        = N_IN_DEF,
  parameter int unsigned N_OUT       = N_OUT_DEF,
  parameter int unsigned IN_W        = 4,
  parameter int unsigned OUT_W       = 4,
  parameter int unsigned WA_W        = 8,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                  clock_in,
  input  logic                  rst,
  dense_tick_sequencer_if.slave bus
);

  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(N_IN - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(N_OUT - 1);

  seq_state_e       state_q;
  logic             busy_q;
  logic [IN_W-1:0]  in_idx_q;
  logic [OUT_W-1:0] out_idx_q;
  logic [WA_W-1:0]  w_addr_q;
  logic             mac_clr_q;
  logic             mac_en_q;
  logic             acc_store_q;
  logic             done_q;
  logic             tick_err_q;

  logic             tick_rise;
  logic             wdog_trip;

  tick_edge_detect u_edge (
    .clock_in (clock_in),
    .rst      (rst),
    .tick_i   (bus.tick_in),
    .rise_o   (tick_rise)
  );

`ifdef TICK_WATCHDOG_EN
  localparam int unsigned     WD_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_q;

  // Counts busy cycles since the last tick rise; trips on the cycle that
  // would bring it to WDOG_CYCLES.
  assign wdog_trip = busy_q & ~tick_rise & (wdog_q == WD_LAST);

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (!busy_q || tick_rise || wdog_trip) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  // No watchdog: never trips. The parameter term keeps it referenced.
  assign wdog_trip = (WDOG_CYCLES == 0) & 1'b0;
`endif

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      w_addr_q    <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      acc_store_q <= 1'b0;
      done_q      <= 1'b0;
      tick_err_q  <= 1'b0;
    end else begin
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      acc_store_q <= 1'b0;
      done_q      <= 1'b0;

      if (state_q != ST_IDLE && bus.abort) begin
        // Indices hold; the next accepted start clears them.
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (wdog_trip) begin
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        tick_err_q <= 1'b1;
      end else begin
        // Indices must stay stable during their strobe cycle, so they advance
        // on the edge after it. Two tick rises are always at least two
        // cycles apart, so this never collides with the next step.
        if (mac_en_q) begin
          in_idx_q <= (in_idx_q == IN_LAST) ? '0 : in_idx_q + 1'b1;
          w_addr_q <= w_addr_q + 1'b1;
        end
        if (acc_store_q && out_idx_q != OUT_LAST) begin
          out_idx_q <= out_idx_q + 1'b1;
        end

        case (state_q)
          ST_IDLE: begin
            // Tick rises are discarded here; abort beats a simultaneous start.
            if (bus.start && !bus.abort) begin
              state_q    <= ST_CLEAR;
              busy_q     <= 1'b1;
              in_idx_q   <= '0;
              out_idx_q  <= '0;
              w_addr_q   <= '0;
              tick_err_q <= 1'b0;
            end
          end
          ST_CLEAR: begin
            if (tick_rise) begin
              mac_clr_q <= 1'b1;
              state_q   <= ST_MAC;
            end
          end
          ST_MAC: begin
            if (tick_rise) begin
              mac_en_q <= 1'b1;
              if (in_idx_q == IN_LAST) begin
                state_q <= ST_STORE;
              end
            end
          end
          ST_STORE: begin
            if (tick_rise) begin
              acc_store_q <= 1'b1;
              state_q     <= (out_idx_q == OUT_LAST) ? ST_DONE : ST_CLEAR;
            end
          end
          ST_DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_idx    = in_idx_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.acc_store = acc_store_q;
  assign bus.done      = done_q;
  assign bus.tick_err  = tick_err_q;

endmodule
`default_nettype wire

// File: doc/dense_tick_sequencer.md
Name: dense_tick_sequencer

Overview:
Consumer end of the divided dense-layer tick. The clock divider emits a periodic high pulse on its output: high for DIVISOR/4 cycles out of every DIVISOR cycles. This block receives that pulse train on tick_in, on the same clock, and converts each rising edge into exactly one dense-layer step. It issues input/weight read addresses and single-cycle MAC control strobes (clear, accumulate, store) for all N_OUT neurons × N_IN inputs, then reports completion.

Parameters:
N_IN, 16, inputs per neuron (≥2)
N_OUT, 10, neurons in layer (≥1)
IN_W, 4, width of in_idx (holds N_IN-1)
OUT_W, 4, width of out_idx (holds N_OUT-1)
WA_W, 8, width of w_addr (holds N_IN*N_OUT-1)
WDOG_CYCLES, 64, watchdog timeout in clock cycles (used only with the optional feature)

Ports:
clock_in  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset
tick_in  in  1  divided tick from clock divider (level, same domain)
start  in  1  begin a layer pass; honoured only in IDLE
abort  in  1  synchronous abort; FSM returns to IDLE next cycle, no done
busy  out  1  high from cycle after accepted start until return to IDLE
in_idx  out  IN_W  current input index
out_idx  out  OUT_W  current neuron index
w_addr  out  WA_W  weight address = out_idx*N_IN + in_idx (running counter, no multiplier)
mac_clr  out  1  1-cycle: clear accumulator
mac_en  out  1  1-cycle: accumulate in[in_idx]*w[w_addr]
acc_store  out  1  1-cycle: write accumulator to out[out_idx]
done  out  1  1-cycle pulse at pass completion
tick_err  out  1  sticky watchdog error (tied 0 without the feature)

Behaviour:
- rst low, asynchronous: all outputs 0, FSM=IDLE, tick_q=0, all counters 0. Release is synchronous to clock_in.
- Edge detect: tick_q <= tick_in; tick_rise = tick_in & ~tick_q. A tick held high N cycles counts once. A tick high out of reset counts as a rise on the first cycle.
- All outputs are registered. A strobe caused by tick_rise at edge k is high for exactly the cycle following edge k. Indices and w_addr are valid in that same cycle.
- IDLE: busy=0. start=1 → CLEAR; counters zeroed; busy=1 next cycle. tick_rise in IDLE is discarded.
- CLEAR: on tick_rise → pulse mac_clr, in_idx=0 → MAC.
- MAC: on each tick_rise → pulse mac_en with the current indices. After the strobe, in_idx++ and w_addr++.
  - On the rise where in_idx==N_IN-1: mac_en pulses, in_idx wraps to 0, → STORE.
- STORE: on tick_rise → pulse acc_store with the current out_idx.
  - If out_idx==N_OUT-1 → DONE.
  - Else out_idx++ → CLEAR.
- DONE: pulse done 1 cycle, busy=0, → IDLE. No tick required.
- Ticks per pass = N_OUT*(N_IN+2). Default: 180.
- start while busy: ignored. start and abort together in IDLE: abort wins, stays IDLE.
- abort in any non-IDLE state: next cycle FSM=IDLE, busy=0, strobes 0, done not asserted. Indices hold; they are cleared on the next start.
- w_addr wrap: cannot occur when WA_W is sized per its parameter description.
- Strobes are mutually exclusive; at most one is high per cycle.

Optional Feature:
Macro TICK_WATCHDOG_EN.
- Defined: a cycle counter runs while busy and clears on every tick_rise.
  - If it reaches WDOG_CYCLES: tick_err=1 (sticky until rst or next accepted start), FSM → IDLE, no done.
- Undefined: counter absent; tick_err constant 0; behaviour otherwise identical.

Decomposition:
- Package dense_seq_pkg: FSM state encoding (IDLE, CLEAR, MAC, STORE, DONE) and default N_IN/N_OUT constants.
- One sub-module, tick_edge_detect (tick_q register plus rise output), reusable by other layer sequencers. Everything else stays in one block.

Test Plan:
- Reset mid-MAC: assert rst at in_idx=5 → all outputs 0 immediately; after release, busy=0 and tick ignored until start.
- Nominal pass, N_IN=16, N_OUT=10, divider pattern period 4, high 1 → exactly 10 mac_clr, 160 mac_en, 10 acc_store, 1 done. w_addr sequence 0..159 with no gaps; last acc_store has out_idx=9.
- Long tick: tick_in held high 7 cycles during MAC → exactly one mac_en, in_idx advances by 1.
- start while busy at out_idx=3 → ignored; pass completes normally with a single done.
- abort during STORE at out_idx=4 → next cycle busy=0, no acc_store, no done. New start → w_addr restarts at 0.
- TICK_WATCHDOG_EN, WDOG_CYCLES=64: stop ticks in MAC → tick_err=1 after 64 cycles, busy=0, done=0. New start clears tick_err.
